// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage encodings and the skid/IF-ID entry layout.
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_FULL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] INSTR_WORD_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_target_calc.sv
// Redirect detection and target computation for the instruction held in ID.
module fetch_target_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_id,
    input  logic [25:0] instr_id,
    input  logic [31:0] jr_pc,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    output logic        redirect,
    output logic [31:0] target
);
    logic [31:0] pc_next;
    logic [31:0] br_off;

    assign pc_next  = pc_id + INSTR_WORD_BYTES;
    assign br_off   = {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    assign redirect = jump_branch | jump_target | jump_reg;

    always_comb begin
        if (jump_reg)
            target = jr_pc;
        else if (jump_target)
            target = {pc_next[31:28], instr_id[25:0], 2'b00};
        else
            target = pc_next + br_off;
    end
endmodule

// File: rtl/fetch_unit.sv
// MIPS fetch stage: owns the fetch PC, keeps one imem request in flight, holds IF/ID.
// Build option FETCH_MISALIGN_TRAP_EN adds misalign_id for non-word-aligned redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_id,
`endif
    output logic        valid_id
);
    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, req_pc_q, redir_q;
    logic         redir_pend_q;
    fetch_entry_t skid_q;
    logic [31:0]  pc_id_q, instr_id_q;
    logic         valid_id_q;

    logic         ctl, capture, issue, load_mem, load_skid, fill_skid;
    logic [31:0]  tgt, tgt_al, issue_addr, ld_pc, ld_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic         req_mis_q, skid_mis_q, redir_mis_q, mis_id_q, issue_mis, ld_mis;
`endif

    fetch_target_calc u_target (
        .pc_id       (pc_id_q),
        .instr_id    (instr_id_q[25:0]),
        .jr_pc       (jr_pc),
        .jump_branch (jump_branch),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .redirect    (ctl),
        .target      (tgt)
    );

    assign capture = valid_id_q & ~stall & ctl;
    assign tgt_al  = tgt & ~(INSTR_WORD_BYTES - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: state_d = FETCH_WAIT;
            FETCH_WAIT: if (imem_rvalid && stall) state_d = FETCH_FULL;
            FETCH_FULL: if (!stall) state_d = FETCH_WAIT;
            default:    state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        issue     = 1'b0;
        load_mem  = 1'b0;
        load_skid = 1'b0;
        fill_skid = 1'b0;
        case (state_q)
            FETCH_IDLE: issue = 1'b1;
            FETCH_WAIT: begin
                load_mem  = imem_rvalid & ~stall;
                fill_skid = imem_rvalid & stall;
                issue     = imem_rvalid & ~stall;
            end
            FETCH_FULL: begin
                load_skid = ~stall;
                issue     = ~stall;
            end
            default: ;
        endcase
        // A redirect captured in the issuing cycle bypasses the pending register.
        if (capture)           issue_addr = tgt_al;
        else if (redir_pend_q) issue_addr = redir_q;
        else                   issue_addr = fetch_pc_q;
        ld_pc    = load_skid ? skid_q.pc    : req_pc_q;
        ld_instr = load_skid ? skid_q.instr : imem_rdata;
`ifdef FETCH_MISALIGN_TRAP_EN
        issue_mis = capture ? (|tgt[1:0]) : (redir_pend_q & redir_mis_q);
        ld_mis    = load_skid ? skid_mis_q : req_mis_q;
        if (ld_mis) ld_instr = NOP_INSTR;
`endif
    end

    assign imem_req  = issue & ~rst;
    assign imem_addr = issue_addr;
    assign pc_id     = pc_id_q;
    assign instr_id  = instr_id_q;
    assign valid_id  = valid_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            redir_q      <= '0;
            redir_pend_q <= 1'b0;
            skid_q       <= '0;
            pc_id_q      <= '0;
            instr_id_q   <= NOP_INSTR;
            valid_id_q   <= 1'b0;
        end else begin
            if (issue) begin
                req_pc_q     <= issue_addr;
                fetch_pc_q   <= issue_addr + INSTR_WORD_BYTES;
                redir_pend_q <= 1'b0;
            end else if (capture) begin
                redir_q      <= tgt_al;
                redir_pend_q <= 1'b1;
            end
            if (fill_skid) begin
                skid_q.pc    <= req_pc_q;
                skid_q.instr <= imem_rdata;
            end
            if (load_mem || load_skid) begin
                pc_id_q    <= ld_pc;
                instr_id_q <= ld_instr;
                valid_id_q <= 1'b1;
            end else if (!stall) begin
                instr_id_q <= NOP_INSTR;
                valid_id_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            req_mis_q   <= 1'b0;
            skid_mis_q  <= 1'b0;
            redir_mis_q <= 1'b0;
            mis_id_q    <= 1'b0;
        end else begin
            if (issue) req_mis_q <= issue_mis;
            if (capture && !issue) redir_mis_q <= |tgt[1:0];
            if (fill_skid) skid_mis_q <= req_mis_q;
            if (load_mem || load_skid) mis_id_q <= ld_mis;
            else if (!stall)           mis_id_q <= 1'b0;
        end
    end

    assign misalign_id = mis_id_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing sequences, a redirect vector table,
// and randomized stall/latency/control traffic against a transaction-level fetch model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, jb, jt, jr, imem_req, imem_rvalid, valid_id;
    logic [31:0] jr_pc, imem_addr, imem_rdata, pc_id, instr_id;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_id;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_branch(jb), .jump_target(jt), .jump_reg(jr), .jr_pc(jr_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .pc_id(pc_id), .instr_id(instr_id),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_id(misalign_id),
`endif
        .valid_id(valid_id)
    );

    int errors = 0;
    int checks = 0;

    // stimulus knobs
    bit          rst_cmd, rand_ctl, tbl_on, ovr_on;
    int          stall_mode, lat_fix;
    logic [31:0] t_br_pc, t_jrv, ovr_addr, ovr_instr;
    logic [2:0]  t_flags;

    // memory and reference model state
    int          mem_cnt;
    logic [31:0] mem_a;
    typedef struct { logic [31:0] pc; bit mis; } fent_t;
    fent_t       fq[$];
    logic [31:0] reqlog[$];
    logic [31:0] exp_next, m_pc, m_instr, last_req, last_cap_pc;
    bit          exp_mis, m_valid, m_mis, prev_stall, prev_rst;

    typedef struct {
        logic [31:0] br_pc;
        logic [31:0] instr;
        logic [2:0]  flags;   // {jr, jt, jb}
        logic [31:0] jrv;
        int          lat;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (ovr_on && w == ovr_addr) return ovr_instr;
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [31:0] rv, input logic [2:0] f);
        logic [31:0] nxt;
        int          off;
        nxt = pc + 32'd4;
        if (f[2]) return rv;
        if (f[1]) return (nxt & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        off = $signed(ins[15:0]);
        return nxt + 32'(off * 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_next    = RESET_PC;
        exp_mis     = 1'b0;
        fq.delete();
        reqlog.delete();
        mem_cnt     = 0;
        m_valid     = 1'b0;
        m_pc        = 32'h0;
        m_instr     = 32'h0;
        m_mis       = 1'b0;
        last_req    = 32'hFFFF_FFF0;
        last_cap_pc = 32'hFFFF_FFF0;
    endtask

    task automatic monitor();
        logic        mis_act;
        logic [31:0] t;
        fent_t       e;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_act = misalign_id;
`else
        mis_act = 1'b0;
`endif
        if (prev_rst) begin
            chk("rst_valid", {31'b0, valid_id}, 32'd0);
            chk("rst_instr", instr_id, 32'h0);
            chk("rst_pc", pc_id, 32'h0);
            chk("rst_mis", {31'b0, mis_act}, 32'd0);
        end else if (prev_stall) begin
            chk("hold_valid", {31'b0, valid_id}, {31'b0, m_valid});
            if (m_valid) begin
                chk("hold_pc", pc_id, m_pc);
                chk("hold_instr", instr_id, m_instr);
                chk("hold_mis", {31'b0, mis_act}, {31'b0, m_mis});
            end
        end else if (valid_id) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL id_unexpected: got pc %h expected no instruction", pc_id);
            end else begin
                e       = fq.pop_front();
                m_valid = 1'b1;
                m_pc    = e.pc;
                m_mis   = e.mis;
                m_instr = e.mis ? 32'h0 : mem_word(e.pc);
                chk("id_pc", pc_id, m_pc);
                chk("id_instr", instr_id, m_instr);
                chk("id_mis", {31'b0, mis_act}, {31'b0, m_mis});
            end
        end else begin
            m_valid = 1'b0;
            chk("bubble_instr", instr_id, 32'h0);
            chk("bubble_pc", pc_id, m_pc);
        end

        if (rst) chk("req_in_reset", {31'b0, imem_req}, 32'd0);

        if (!rst && m_valid && !stall && (jr || jt || jb)) begin
            chk("dslot_issued", last_req, m_pc + 32'd4);
            t        = ref_target(m_pc, m_instr, jr_pc, {jr, jt, jb});
            exp_next = t & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_mis  = (t[1:0] != 2'b00);
`endif
            last_cap_pc = m_pc;
        end

        if (imem_req && !rst) begin
            chk("one_outstanding", 32'(mem_cnt), 32'd0);
            chk("req_addr", imem_addr, exp_next);
            fq.push_back('{pc: exp_next, mis: exp_mis});
            reqlog.push_back(imem_addr);
            last_req = exp_next;
            exp_next = exp_next + 32'd4;
            exp_mis  = 1'b0;
            mem_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(3, 1));
            mem_a    = imem_addr;
        end

        prev_stall = stall;
        prev_rst   = rst;
        if (rst) model_reset();
    endtask

    task automatic step();
        @(negedge clk);
        rst         = rst_cmd;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_a);
            end
        end
        stall = (stall_mode < 0) ? ($urandom_range(3) == 0) : (stall_mode != 0);
        {jr, jt, jb} = 3'b000;
        jr_pc = $urandom;
        if (rand_ctl && $urandom_range(5) == 0 && !(valid_id && pc_id == last_cap_pc + 32'd4))
            {jr, jt, jb} = 3'($urandom_range(7));
        if (tbl_on && valid_id) begin
            if (pc_id == 32'h0) begin
                jr    = 1'b1;
                jr_pc = t_br_pc;
            end else if (pc_id == t_br_pc) begin
                {jr, jt, jb} = t_flags;
                jr_pc        = t_jrv;
            end
        end
        #1;
        monitor();
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        step();
        step();
        rst_cmd = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0100, 32'h1000_0004, 3'b001, 32'h0, 1, 32'h0000_0114};
        tbl[1] = '{32'h0000_0100, 32'h1000_0004, 3'b001, 32'h0, 3, 32'h0000_0114};
        tbl[2] = '{32'h0000_0040, 32'h0000_0008, 3'b100, 32'h0000_2000, 3, 32'h0000_2000};
        tbl[3] = '{32'hF000_0010, 32'h0800_0040, 3'b010, 32'h0, 1, 32'hF000_0100};
        tbl[4] = '{32'h0000_1000, 32'h1000_FFFC, 3'b001, 32'h0, 2, 32'h0000_0FF4};
        tbl[5] = '{32'hFFFF_FFF0, 32'h1000_0008, 3'b001, 32'h0, 1, 32'h0000_0014};
        tbl[6] = '{32'h0000_0200, 32'h0800_0123, 3'b110, 32'h0000_3000, 2, 32'h0000_3000};
        tbl[7] = '{32'h0000_0040, 32'h0000_0008, 3'b100, 32'h0000_2002, 2, 32'h0000_2000};
        tbl[8] = '{32'h0FFF_FFFC, 32'h0800_0010, 3'b010, 32'h0, 1, 32'h1000_0040};

        rst = 1'b1; stall = 1'b0; {jr, jt, jb} = 3'b000; jr_pc = 32'h0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        rst_cmd = 1'b1; rand_ctl = 1'b0; tbl_on = 1'b0; ovr_on = 1'b0;
        stall_mode = 0; lat_fix = 1; t_br_pc = 32'h0; t_jrv = 32'h0; t_flags = 3'b000;
        ovr_addr = 32'h0; ovr_instr = 32'h0; mem_a = 32'h0;
        prev_stall = 1'b0; prev_rst = 1'b1;
        model_reset();

        // reset release with 1-cycle memory, then a 3-cycle stall over a response
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("boot_req", {31'b0, imem_req}, 32'd1);
            chk("boot_addr", imem_addr, 32'((c - 1) * 4));
            chk("boot_valid", {31'b0, valid_id}, (c >= 3) ? 32'd1 : 32'd0);
        end
        stall_mode = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_noreq", {31'b0, imem_req}, 32'd0);
            chk("stall_pc", pc_id, 32'h0000_000C);
        end
        stall_mode = 0;
        step();
        chk("release_req", {31'b0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, 32'h0000_0014);
        step();
        chk("skid_pc", pc_id, 32'h0000_0010);
        chk("skid_valid", {31'b0, valid_id}, 32'd1);

        // redirect vector table
        for (int i = 0; i < 9; i++) begin
            bit found;
            lat_fix = tbl[i].lat;
            ovr_on = 1'b1; ovr_addr = tbl[i].br_pc; ovr_instr = tbl[i].instr;
            t_br_pc = tbl[i].br_pc; t_flags = tbl[i].flags; t_jrv = tbl[i].jrv;
            do_reset();
            tbl_on = 1'b1;
            for (int c = 0; c < 40; c++) step();
            tbl_on = 1'b0;
            found = 1'b0;
            for (int k = 1; k + 1 < reqlog.size(); k++) begin
                if (!found && reqlog[k-1] == tbl[i].br_pc && reqlog[k] == tbl[i].br_pc + 32'd4) begin
                    found = 1'b1;
                    chk($sformatf("tbl%0d_target", i), reqlog[k+1], tbl[i].exp);
                end
            end
            if (!found) begin
                checks++; errors++;
                $display("FAIL tbl%0d_path: branch at %h and delay slot never requested", i, tbl[i].br_pc);
            end
        end
        ovr_on = 1'b0;

        // reset while a 3-cycle request is outstanding
        lat_fix = 3;
        do_reset();
        for (int c = 0; c < 9; c++) step();
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
        step();
        chk("midrst_valid", {31'b0, valid_id}, 32'd0);
        chk("midrst_req", {31'b0, imem_req}, 32'd1);
        chk("midrst_addr", imem_addr, RESET_PC);

        // randomized stalls, latencies, controls and occasional resets
        lat_fix = 0; stall_mode = -1; rand_ctl = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst_cmd = ($urandom_range(499) == 0);
            step();
        end
        rst_cmd = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
